// File: rtl/cve2_pkg.sv
// Shared CVE2 types used by the execute-stage multiply/divide unit.
package cve2_pkg;

   typedef enum logic [1:0] {
      MD_OP_MULL = 2'b00,
      MD_OP_MULH = 2'b01,
      MD_OP_DIV  = 2'b10,
      MD_OP_REM  = 2'b11
   } md_op_e;

   typedef enum logic [1:0] {
      MD_IDLE = 2'b00,
      MD_CALC = 2'b01,
      MD_FIX  = 2'b10,
      MD_DONE = 2'b11
   } md_state_e;

endpackage

// File: rtl/cve2_multdiv_iter.sv
// Iterative 32-bit multiply/divide: one shared 33-bit adder, 32 shift-add or
// restoring-divide steps on operand magnitudes, sign fix applied at the end.
//
// state | meaning
// IDLE  | ready_o high, waiting for an accepted request
// CALC  | one shift-add / trial-subtract per cycle, cnt_q counts 31..0
// FIX   | sign correction and result selection, loads result_o
// DONE  | valid_o high until the consumer asserts ready_i
module cve2_multdiv_iter
   import cve2_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        valid_i,
   output logic        ready_o,
   input  md_op_e      operator_i,
   input  logic [1:0]  signed_mode_i,
   input  logic [31:0] op_a_i,
   input  logic [31:0] op_b_i,
   input  logic        kill_i,
   output logic        valid_o,
   input  logic        ready_i,
   output logic [31:0] result_o
);

   localparam logic [1:0] S_IDLE = MD_IDLE;
   localparam logic [1:0] S_CALC = MD_CALC;
   localparam logic [1:0] S_FIX  = MD_FIX;
   localparam logic [1:0] S_DONE = MD_DONE;

   logic [1:0]  state_q, state_d;
   logic [4:0]  cnt_q;
   md_op_e      op_q;
   logic        neg_res_q, neg_rem_q;
   logic [31:0] hi_q, lo_q, opnd_q, result_q;

   logic        accept, is_div_i, div_by_zero, div_mode;
   logic        sign_a, sign_b;
   logic [31:0] mag_a, mag_b;
   logic [32:0] add_a, add_b;
   logic        add_cin;
   logic [33:0] add_sum;
   logic        trial_ok;
   logic [32:0] mul_sel;
   logic [63:0] prod, prod_fix;
   logic [31:0] quot_fix, rem_fix, fix_result;

   assign ready_o  = (state_q == S_IDLE);
   assign valid_o  = (state_q == S_DONE);
   assign result_o = result_q;

   assign accept      = valid_i && ready_o && !kill_i;
   assign is_div_i    = (operator_i == MD_OP_DIV) || (operator_i == MD_OP_REM);
   assign div_by_zero = is_div_i && (op_b_i == 32'd0);
   assign div_mode    = (op_q == MD_OP_DIV) || (op_q == MD_OP_REM);

   assign sign_a = signed_mode_i[0] & op_a_i[31];
   assign sign_b = signed_mode_i[1] & op_b_i[31];
   assign mag_a  = sign_a ? (~op_a_i + 32'd1) : op_a_i;
   assign mag_b  = sign_b ? (~op_b_i + 32'd1) : op_b_i;

   // Division subtracts via a + ~b + 1; the carry out means the trial was non-negative.
   always_comb begin
      if (div_mode) begin
         add_a   = {hi_q, lo_q[31]};
         add_b   = ~{1'b0, opnd_q};
         add_cin = 1'b1;
      end else begin
         add_a   = {1'b0, hi_q};
         add_b   = {1'b0, opnd_q};
         add_cin = 1'b0;
      end
   end

   assign add_sum  = {1'b0, add_a} + {1'b0, add_b} + {33'd0, add_cin};
   assign trial_ok = add_sum[33];
   assign mul_sel  = lo_q[0] ? add_sum[32:0] : {1'b0, hi_q};

   assign prod     = {hi_q, lo_q};
   assign prod_fix = neg_res_q ? (~prod + 64'd1) : prod;
   assign quot_fix = neg_res_q ? (~lo_q + 32'd1) : lo_q;
   assign rem_fix  = neg_rem_q ? (~hi_q + 32'd1) : hi_q;

   always_comb begin
      unique case (op_q)
         MD_OP_MULL: fix_result = prod_fix[31:0];
         MD_OP_MULH: fix_result = prod_fix[63:32];
         MD_OP_DIV:  fix_result = quot_fix;
         MD_OP_REM:  fix_result = rem_fix;
         default:    fix_result = 32'd0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: if (accept) state_d = div_by_zero ? S_DONE : S_CALC;
         S_CALC: if (cnt_q == 5'd0) state_d = S_FIX;
         S_FIX:  state_d = S_DONE;
         S_DONE: if (ready_i) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (kill_i) state_d = S_IDLE;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= S_IDLE;
         cnt_q     <= 5'd0;
         op_q      <= MD_OP_MULL;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         hi_q      <= 32'd0;
         lo_q      <= 32'd0;
         opnd_q    <= 32'd0;
         result_q  <= 32'd0;
      end else begin
         state_q <= state_d;
         unique case (state_q)
            S_IDLE: begin
               if (accept) begin
                  op_q      <= operator_i;
                  neg_res_q <= sign_a ^ sign_b;
                  neg_rem_q <= sign_a;
                  cnt_q     <= 5'd31;
                  hi_q      <= 32'd0;
                  lo_q      <= is_div_i ? mag_a : mag_b;
                  opnd_q    <= is_div_i ? mag_b : mag_a;
                  // Division by zero skips the datapath entirely, no sign fix.
                  if (div_by_zero) begin
                     result_q <= (operator_i == MD_OP_DIV) ? 32'hFFFF_FFFF : op_a_i;
                  end
               end
            end
            S_CALC: begin
               if (cnt_q != 5'd0) cnt_q <= cnt_q - 5'd1;
               if (div_mode) begin
                  hi_q <= trial_ok ? add_sum[31:0] : {hi_q[30:0], lo_q[31]};
                  lo_q <= {lo_q[30:0], trial_ok};
               end else begin
                  hi_q <= mul_sel[32:1];
                  lo_q <= {mul_sel[0], lo_q[31:1]};
               end
            end
            S_FIX: begin
               if (!kill_i) result_q <= fix_result;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cve2_multdiv_iter.sv
// Scoreboard bench for cve2_multdiv_iter: directed vectors with hand-computed
// results and latencies, checked by a monitor on each output handshake.
module tb_cve2_multdiv_iter;
   import cve2_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        valid_i = 1'b0;
   logic        ready_o;
   md_op_e      operator_i = MD_OP_MULL;
   logic [1:0]  signed_mode_i = 2'b00;
   logic [31:0] op_a_i = 32'd0;
   logic [31:0] op_b_i = 32'd0;
   logic        kill_i = 1'b0;
   logic        valid_o;
   logic        ready_i = 1'b1;
   logic [31:0] result_o;

   typedef struct {
      logic [31:0] res;
      int          lat;
      string       name;
   } exp_t;

   exp_t sb[$];
   int   tests = 0;
   int   errors = 0;
   int   cyc = 0;
   int   accept_cyc = 0;
   int   first_cyc = 0;
   logic vprev = 1'b0;

   cve2_multdiv_iter dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .valid_i       (valid_i),
      .ready_o       (ready_o),
      .operator_i    (operator_i),
      .signed_mode_i (signed_mode_i),
      .op_a_i        (op_a_i),
      .op_b_i        (op_b_i),
      .kill_i        (kill_i),
      .valid_o       (valid_o),
      .ready_i       (ready_i),
      .result_o      (result_o)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: pops the scoreboard on every output handshake.
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         vprev = 1'b0;
      end else begin
         if (valid_o && !vprev) first_cyc = cyc;
         vprev = valid_o;
         if (valid_o && ready_i) begin
            tests++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL unexpected_valid: got result %h with nothing expected", result_o);
            end else begin
               e = sb.pop_front();
               if (result_o !== e.res) begin
                  errors++;
                  $display("FAIL %s result: got %h expected %h", e.name, result_o, e.res);
               end
               tests++;
               if (first_cyc - accept_cyc + 1 != e.lat) begin
                  errors++;
                  $display("FAIL %s latency: got %0d expected %0d", e.name,
                           first_cyc - accept_cyc + 1, e.lat);
               end
            end
         end
      end
   end

   task automatic issue(input md_op_e op, input logic [1:0] mode, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] res, input int lat,
                        input string name);
      exp_t e;
      e.res = res; e.lat = lat; e.name = name;
      sb.push_back(e);
      check({name, " ready_before"}, {31'd0, ready_o}, 32'd1);
      operator_i = op; signed_mode_i = mode; op_a_i = a; op_b_i = b; valid_i = 1'b1;
      @(posedge clk);
      #1;
      accept_cyc = cyc;
      valid_i = 1'b0;
   endtask

   task automatic wait_done(input string name);
      for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
      if (sb.size() != 0) begin
         tests++; errors++;
         $display("FAIL %s timeout: got %0d pending expected 0", name, sb.size());
         sb.delete();
      end
      #1;
   endtask

   task automatic run(input md_op_e op, input logic [1:0] mode, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] res, input int lat,
                      input string name);
      issue(op, mode, a, b, res, lat, name);
      wait_done(name);
   endtask

   initial begin
      logic [31:0] held;
      logic        seen;

      repeat (2) @(posedge clk);
      #1;
      check("rst_ready", {31'd0, ready_o}, 32'd1);
      check("rst_valid", {31'd0, valid_o}, 32'd0);
      check("rst_result", result_o, 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      run(MD_OP_MULL, 2'b11, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, "mull_neg");
      run(MD_OP_MULH, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 34, "mulh");
      run(MD_OP_MULH, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, "mulhu");
      run(MD_OP_MULH, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, "mulhsu");
      run(MD_OP_DIV,  2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, "div_neg");
      run(MD_OP_REM,  2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, "rem_neg");
      run(MD_OP_DIV,  2'b00, 32'd100, 32'd7, 32'd14, 34, "divu");
      run(MD_OP_REM,  2'b00, 32'd100, 32'd7, 32'd2, 34, "remu");
      run(MD_OP_DIV,  2'b11, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 1, "div_zero");
      run(MD_OP_REM,  2'b11, 32'h1234_5678, 32'd0, 32'h1234_5678, 1, "rem_zero");
      run(MD_OP_DIV,  2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34, "div_ovf");
      run(MD_OP_REM,  2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 34, "rem_ovf");
      run(MD_OP_DIV,  2'b00, 32'hFFFF_FFFF, 32'd3, 32'h5555_5555, 34, "divu_big");

      // Kill 10 cycles into CALC: nothing may come out.
      issue(MD_OP_DIV, 2'b00, 32'd1000, 32'd3, 32'd333, 34, "killed");
      void'(sb.pop_back());
      repeat (10) @(posedge clk);
      #1;
      kill_i = 1'b1;
      @(posedge clk);
      #1;
      kill_i = 1'b0;
      check("kill_ready", {31'd0, ready_o}, 32'd1);
      check("kill_valid", {31'd0, valid_o}, 32'd0);
      seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         seen |= valid_o;
      end
      check("kill_no_valid", {31'd0, seen}, 32'd0);
      check("kill_result_held", result_o, 32'h5555_5555);
      @(posedge clk);
      #1;

      // Kill together with a request in IDLE: the request is dropped.
      operator_i = MD_OP_MULL; op_a_i = 32'd2; op_b_i = 32'd2; valid_i = 1'b1; kill_i = 1'b1;
      @(posedge clk);
      #1;
      valid_i = 1'b0; kill_i = 1'b0;
      check("kill_idle_ready", {31'd0, ready_o}, 32'd1);

      run(MD_OP_MULL, 2'b00, 32'd3, 32'd5, 32'd15, 34, "mull_after_kill");

      // Backpressure: result and valid must hold while ready_i is low.
      ready_i = 1'b0;
      issue(MD_OP_MULL, 2'b00, 32'h0000_1234, 32'h0000_0010, 32'h0001_2340, 34, "bp");
      for (int i = 0; i < 100 && !valid_o; i++) @(negedge clk);
      check("bp_valid_seen", {31'd0, valid_o}, 32'd1);
      held = result_o;
      check("bp_result_first", held, 32'h0001_2340);
      repeat (5) begin
         @(negedge clk);
         check("bp_valid_hold", {31'd0, valid_o}, 32'd1);
         check("bp_result_hold", result_o, held);
         check("bp_ready_low", {31'd0, ready_o}, 32'd0);
      end
      @(posedge clk);
      #1;
      ready_i = 1'b1;
      wait_done("bp");

      // Asynchronous reset mid-CALC.
      issue(MD_OP_MULL, 2'b00, 32'd9, 32'd9, 32'd81, 34, "reset_mid");
      void'(sb.pop_back());
      repeat (10) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("rst_mid_valid", {31'd0, valid_o}, 32'd0);
      check("rst_mid_result", result_o, 32'd0);
      check("rst_mid_ready", {31'd0, ready_o}, 32'd1);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;

      run(MD_OP_MULL, 2'b11, 32'hFFFF_FFFE, 32'hFFFF_FFFA, 32'd12, 34, "mull_after_rst");

      repeat (3) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule
